// File: rtl/ws2812_frame_seq.sv
// ws2812_frame_seq - frame buffer and pixel sequencer for a ws2812 serial driver.
// A host port writes NUM_LEDS 24-bit pixels {R,G,B} into a small RAM. A show
// request streams them out in index order over a we/ready handshake. A latch
// gap follows, and then a one-cycle done pulse.
// Optional feature: define WS2812_FRAME_SEQ_BRIGHTNESS_EN to add a registered
// global-brightness scale stage: c' = (c * (brightness + 1)) >> 8.
module ws2812_frame_seq #(
    parameter int NUM_LEDS    = 8,
    parameter int LATCH_TICKS = 4000,
    parameter int AW          = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          show,
    input  logic [7:0]    brightness,
    input  logic          ready,
    output logic [7:0]    red,
    output logic [7:0]    green,
    output logic [7:0]    blue,
    output logic          we,
    output logic          busy,
    output logic          done
);

    // RAM index width can be narrower than the host address, which may be
    // widened so that out-of-range indices can be expressed and rejected.
    localparam int RAM_AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int CW     = $clog2(LATCH_TICKS + 1);

    localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_LEDS - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_SCALE   = 3'd2,
        S_PRESENT = 3'd3,
        S_LATCH   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [23:0]   pix_q, pix_d;
    logic          we_q, we_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [23:0]   mem_q [0:NUM_LEDS-1];
    logic [31:0]   wr_addr_ext_s;
    logic          wr_ok_s;
    logic [23:0]   rd_pix_s;

    assign wr_addr_ext_s = {{(32 - AW){1'b0}}, wr_addr};
    assign wr_ok_s       = wr_en && (wr_addr_ext_s < 32'(NUM_LEDS));
    assign rd_pix_s      = mem_q[idx_q[RAM_AW-1:0]];

`ifdef WS2812_FRAME_SEQ_BRIGHTNESS_EN
    logic [23:0] fetch_q, fetch_d;

    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'h00, c} * ({8'h00, b} + 16'd1);
        return prod[15:8];
    endfunction

    function automatic logic [23:0] scale_pixel(input logic [23:0] p, input logic [7:0] b);
        return {scale_ch(p[23:16], b), scale_ch(p[15:8], b), scale_ch(p[7:0], b)};
    endfunction
`else
    logic brightness_unused_s;
    assign brightness_unused_s = ^brightness;
`endif

    // Pixel RAM: host writes land in any state; out-of-range indices are dropped.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_addr[RAM_AW-1:0]] <= wr_data;
        end
    end

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pix_d   = pix_q;
        we_d    = we_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef WS2812_FRAME_SEQ_BRIGHTNESS_EN
        fetch_d = fetch_q;
`endif
        case (state_q)
            S_IDLE: begin
                we_d = 1'b0;
                if (show) begin
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_FETCH: begin
`ifdef WS2812_FRAME_SEQ_BRIGHTNESS_EN
                fetch_d = rd_pix_s;
                state_d = S_SCALE;
`else
                pix_d   = rd_pix_s;
                we_d    = 1'b1;
                state_d = S_PRESENT;
`endif
            end
`ifdef WS2812_FRAME_SEQ_BRIGHTNESS_EN
            S_SCALE: begin
                pix_d   = scale_pixel(fetch_q, brightness);
                we_d    = 1'b1;
                state_d = S_PRESENT;
            end
`endif
            S_PRESENT: begin
                if (ready) begin
                    we_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = S_LATCH;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    we_d = 1'b1;
                end
            end
            S_LATCH: begin
                // done and the falling busy are registered, so both are
                // launched on the last latch tick to appear together.
                if (cnt_q == LATCH_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                we_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears every output at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            pix_q   <= 24'h000000;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef WS2812_FRAME_SEQ_BRIGHTNESS_EN
            fetch_q <= 24'h000000;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pix_q   <= pix_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef WS2812_FRAME_SEQ_BRIGHTNESS_EN
            fetch_q <= fetch_d;
`endif
        end
    end

    assign red   = pix_q[23:16];
    assign green = pix_q[15:8];
    assign blue  = pix_q[7:0];
    assign we    = we_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_ws2812_frame_seq.sv
// Testbench for ws2812_frame_seq: a cycle-level behavioural model that is
// built from the frame timing rules is compared against the DUT on every
// falling edge. Directed frames add literal expectations for transfer order,
// done spacing, backpressure, dropped writes, ignored show and mid-frame reset.
`timescale 1ns/1ps
module tb_ws2812_frame_seq;

    localparam int N  = 4;
    localparam int L  = 10;
    localparam int AW = 3;
`ifdef WS2812_FRAME_SEQ_BRIGHTNESS_EN
    localparam int PIPE = 2;
`else
    localparam int PIPE = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [23:0]   wr_data = 24'h0;
    logic          show = 1'b0;
    logic [7:0]    brightness = 8'd255;
    logic          ready = 1'b0;
    logic [7:0]    red, green, blue;
    logic          we, busy, done;

    ws2812_frame_seq #(.NUM_LEDS(N), .LATCH_TICKS(L), .AW(AW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .show(show), .brightness(brightness), .ready(ready),
        .red(red), .green(green), .blue(blue), .we(we), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Behavioural model state
    logic [23:0] mem_m [0:N-1];
    logic        m_active = 1'b0;
    int          m_idx = 0;
    int          m_due = -10;
    int          m_done_at = -10;
    logic [23:0] m_fetched = 24'h0;
    logic        exp_we = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
    logic [23:0] exp_pix = 24'h0;

    // Observed transfers and done pulses
    logic [23:0] xfer_pix [$];
    int          xfer_cyc [$];
    int          done_cyc [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Channel scale straight from the brightness rule; b=255 is identity.
    function automatic logic [23:0] model_scale(input logic [23:0] p, input logic [7:0] b);
        int f;
        f = int'(b) + 1;
        return {8'((int'(p[23:16]) * f) / 256), 8'((int'(p[15:8]) * f) / 256),
                8'((int'(p[7:0]) * f) / 256)};
    endfunction

    // Per-cycle compare against the model, then advance the model one cycle.
    always @(negedge clk) begin : cmp
        logic [23:0] nxt_pix;
        logic        nxt_we, nxt_busy, nxt_done;
        cyc++;
        if (!rst) begin
            m_active = 1'b0;
            exp_we = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_pix = 24'h0;
        end
        check("we", 32'(we), 32'(exp_we));
        check("busy", 32'(busy), 32'(exp_busy));
        check("done", 32'(done), 32'(exp_done));
        check("pixel", 32'({red, green, blue}), 32'(exp_pix));
        if (rst) begin
            if (we && ready) begin
                xfer_pix.push_back({red, green, blue});
                xfer_cyc.push_back(cyc);
            end
            if (done) done_cyc.push_back(cyc);
            nxt_we = exp_we; nxt_busy = exp_busy; nxt_done = 1'b0; nxt_pix = exp_pix;
            if (!m_active && !exp_done) begin
                if (show) begin
                    m_active = 1'b1; m_idx = 0; m_due = cyc + 1 + PIPE; m_done_at = -10;
                    nxt_busy = 1'b1;
                end
            end else if (m_active && exp_we && ready) begin
                nxt_we = 1'b0;
                if (m_idx == N - 1) begin
                    m_done_at = cyc + 1 + L; m_due = -10;
                end else begin
                    m_idx++; m_due = cyc + 1 + PIPE;
                end
            end
            if (m_active && cyc == m_due - PIPE) m_fetched = mem_m[m_idx];
            if (m_active && cyc == m_due - 1) begin
                nxt_we  = 1'b1;
                nxt_pix = model_scale(m_fetched, (PIPE == 2) ? brightness : 8'd255);
            end
            if (m_active && cyc + 1 == m_done_at) begin
                nxt_done = 1'b1; nxt_busy = 1'b0; m_active = 1'b0;
            end
            if (wr_en && int'(wr_addr) < N) mem_m[int'(wr_addr)] = wr_data;
            exp_we = nxt_we; exp_busy = nxt_busy; exp_done = nxt_done; exp_pix = nxt_pix;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input int a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_show();
        show = 1'b1;
        tick();
        show = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cyc.size() >= target) break;
            tick();
        end
        check("done_reached", 32'(done_cyc.size() >= target), 32'd1);
    endtask

    task automatic wait_red(input logic [7:0] v, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (we && red == v) begin
                hit = 1'b1;
                break;
            end
        end
        check("pixel_seen", 32'(hit), 32'd1);
    endtask

    task automatic check_xfer(input string name, input int i, input logic [23:0] exp);
        if (i < xfer_pix.size()) check(name, 32'(xfer_pix[i]), 32'(exp));
        else check({name, "_missing"}, 32'(xfer_pix.size()), 32'(i + 1));
    endtask

    int gap;

    initial begin
        // Reset, then idle with show low
        repeat (3) tick();
        rst = 1'b1;
        check("rst_we", 32'(we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pix", 32'({red, green, blue}), 32'h0);
        repeat (5) tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done_cnt", 32'(done_cyc.size()), 32'd0);

        // Load frame; address 4 is out of range and must not alias index 0
        write_px(0, 24'h112233);
        write_px(1, 24'h445566);
        write_px(2, 24'h778899);
        write_px(3, 24'hAABBCC);
        write_px(4, 24'hDEADBE);

        // Basic frame with ready high
        ready = 1'b1;
        xfer_pix.delete(); xfer_cyc.delete();
        pulse_show();
        wait_done(1, 200);
        check("f1_xfers", 32'(xfer_pix.size()), 32'd4);
        check_xfer("f1_px0", 0, 24'h112233);
        check_xfer("f1_px1", 1, 24'h445566);
        check_xfer("f1_px2", 2, 24'h778899);
        check_xfer("f1_px3", 3, 24'hAABBCC);
        if (xfer_cyc.size() == 4 && done_cyc.size() >= 1) begin
            gap = done_cyc[0] - xfer_cyc[3];
            check("f1_done_gap", 32'(gap), 32'd11);
        end else begin
            check("f1_done_gap_data", 32'(xfer_cyc.size()), 32'd4);
        end
        tick();

        // Backpressure on pixel 1, with a write to index 3 and a show while busy
        xfer_pix.delete(); xfer_cyc.delete();
        pulse_show();
        wait_red(8'h44, 50);
        ready = 1'b0;
        write_px(3, 24'h0102F3);
        pulse_show();
        repeat (5) tick();
        ready = 1'b1;
        wait_done(2, 200);
        repeat (30) tick();
        check("f2_done_cnt", 32'(done_cyc.size()), 32'd2);
        check("f2_xfers", 32'(xfer_pix.size()), 32'd4);
        check_xfer("f2_px0", 0, 24'h112233);
        check_xfer("f2_px1", 1, 24'h445566);
        check_xfer("f2_px2", 2, 24'h778899);
        check_xfer("f2_px3", 3, 24'h0102F3);

        // Reset during pixel 2 presentation: immediate clear, no done
        xfer_pix.delete(); xfer_cyc.delete();
        pulse_show();
        wait_red(8'h77, 50);
        ready = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_we", 32'(we), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        ready = 1'b1;
        repeat (40) tick();
        check("mid_rst_done_cnt", 32'(done_cyc.size()), 32'd2);
        check("mid_rst_xfers", 32'(xfer_pix.size()), 32'd2);
        xfer_pix.delete(); xfer_cyc.delete();
        pulse_show();
        wait_done(3, 200);
        check("restart_xfers", 32'(xfer_pix.size()), 32'd4);
        check_xfer("restart_px0", 0, 24'h112233);

`ifdef WS2812_FRAME_SEQ_BRIGHTNESS_EN
        // 0xFF*128>>8 = 0x7F, 0x80*128>>8 = 0x40, 0x40*128>>8 = 0x20
        tick();
        write_px(0, 24'hFF8040);
        brightness = 8'd127;
        xfer_pix.delete(); xfer_cyc.delete();
        pulse_show();
        wait_done(4, 200);
        check_xfer("bri127_px0", 0, 24'h7F4020);
        tick();
        brightness = 8'd255;
        xfer_pix.delete(); xfer_cyc.delete();
        pulse_show();
        wait_done(5, 200);
        check_xfer("bri255_px0", 0, 24'hFF8040);
`endif

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
